// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder_if
//  Brief    : CPU data-memory bus plus console/tohost host-side signals.
//  Revision : 1.0
// ============================================================================
interface data_mem_responder_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN/8-1:0] mem_r;
    logic [XLEN/8-1:0] mem_w;
    logic [XLEN-1:0]   mem_din;
    logic [XLEN-1:0]   mem_dout;
    logic [7:0]        con_data;
    logic              con_valid;
    logic              con_ready;
    logic [7:0]        con_drops;
    logic              halt;
    logic [XLEN-1:0]   halt_code;
    logic              bus_err;

    modport master (
        output mem_addr, mem_r, mem_w, mem_din, con_ready,
        input  mem_dout, con_data, con_valid, con_drops, halt, halt_code, bus_err
    );

    modport slave (
        input  mem_addr, mem_r, mem_w, mem_din, con_ready,
        output mem_dout, con_data, con_valid, con_drops, halt, halt_code, bus_err
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Brief    : Byte-lane data RAM responder with console FIFO and tohost halt.
//  Revision : 1.0
// ============================================================================
module data_mem_responder #(
    parameter int                 XLEN        = 32,
    parameter int                 MEM_BYTES   = 4096,
    parameter logic [XLEN-1:0]    CON_ADDR    = 'h1000_0000,
    parameter logic [XLEN-1:0]    TOHOST_ADDR = 'h1000_0008,
    parameter int                 FIFO_DEPTH  = 8
) (
    input  wire logic             clk,
    input  wire logic             rstl,
    data_mem_responder_if.slave   bus
);
    localparam int c_LANES  = XLEN / 8;
    localparam int c_MIDX_W = $clog2(MEM_BYTES);
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);

    logic [7:0]          r_mem  [MEM_BYTES];
    logic [7:0]          r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [7:0]          r_drops;
    logic                r_halt;
    logic [XLEN-1:0]     r_halt_code;
    logic                r_bus_err;

    logic                w_is_con;
    logic                w_is_th;
    logic                w_is_ram;
    logic [c_LANES-1:0]  w_in_range;
    logic [c_MIDX_W-1:0] w_lane_idx [c_LANES];
    logic                w_full;
    logic                w_pop;
    logic                w_con_wr;
    logic                w_push;
    logic                w_drop;
    logic                w_th_wr;
    logic                w_oor;
    logic [XLEN-1:0]     w_dout;
    logic [XLEN-1:0]     w_th_mask;

    assign w_is_con = (bus.mem_addr == CON_ADDR);
    assign w_is_th  = (bus.mem_addr == TOHOST_ADDR);
    assign w_is_ram = !w_is_con && !w_is_th;

    // Range test uses one extra bit so an address that wraps past zero is out of range.
    for (genvar i = 0; i < c_LANES; i++) begin : g_lane
        assign w_in_range[i] = ({1'b0, bus.mem_addr} + (XLEN+1)'(i)) < (XLEN+1)'(MEM_BYTES);
        assign w_lane_idx[i] = bus.mem_addr[c_MIDX_W-1:0] + c_MIDX_W'(i);
        assign w_th_mask[8*i +: 8] = {8{bus.mem_w[i]}};
    end

    assign w_full   = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_pop    = (r_count != '0) && bus.con_ready;
    assign w_con_wr = w_is_con && bus.mem_w[0] && !r_halt;
    assign w_push   = w_con_wr && (!w_full || w_pop);
    assign w_drop   = w_con_wr && w_full && !w_pop;
    assign w_th_wr  = w_is_th && (|bus.mem_w) && !r_halt;
    assign w_oor    = w_is_ram && (|((bus.mem_r | bus.mem_w) & ~w_in_range));

    always_comb begin
        w_dout = '0;
        for (int i = 0; i < c_LANES; i++) begin
            if (w_is_con) begin
                if (i == 0 && bus.mem_r[0]) w_dout[7:0] = 8'(r_count);
            end else if (w_is_th) begin
                if (bus.mem_r[i]) w_dout[8*i +: 8] = r_halt_code[8*i +: 8];
            end else if (bus.mem_r[i] && w_in_range[i]) begin
                w_dout[8*i +: 8] = r_mem[w_lane_idx[i]];
            end
        end
    end

    // Storage arrays carry no reset; writes in a reset cycle are still suppressed.
    always_ff @(posedge clk) begin
        if (!rstl && !r_halt && w_is_ram) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (bus.mem_w[i] && w_in_range[i]) r_mem[w_lane_idx[i]] <= bus.mem_din[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstl && w_push) r_fifo[r_wr_ptr] <= bus.mem_din[7:0];
    end

    always_ff @(posedge clk) begin
        if (rstl) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_drops     <= '0;
            r_halt      <= 1'b0;
            r_halt_code <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop && r_drops != 8'hFF) r_drops <= r_drops + 8'd1;
            if (w_th_wr) begin
                r_halt      <= 1'b1;
                r_halt_code <= bus.mem_din & w_th_mask;
            end
            if (w_oor) r_bus_err <= 1'b1;
        end
    end

    assign bus.mem_dout  = w_dout;
    assign bus.con_data  = r_fifo[r_rd_ptr];
    assign bus.con_valid = (r_count != '0);
    assign bus.con_drops = r_drops;
    assign bus.halt      = r_halt;
    assign bus.halt_code = r_halt_code;
    assign bus.bus_err   = r_bus_err;
endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Brief    : Directed scoreboard bench for data_mem_responder.
//  Revision : 1.0
// ============================================================================
module tb_data_mem_responder;
    localparam logic [31:0] c_CON    = 32'h1000_0000;
    localparam logic [31:0] c_TOHOST = 32'h1000_0008;
    localparam int          c_MEMB   = 4096;

    logic clk  = 1'b0;
    logic rstl = 1'b1;

    data_mem_responder_if #(.XLEN(32)) bus ();

    data_mem_responder #(
        .XLEN(32), .MEM_BYTES(c_MEMB), .CON_ADDR(c_CON),
        .TOHOST_ADDR(c_TOHOST), .FIFO_DEPTH(8)
    ) dut (
        .clk  (clk),
        .rstl (rstl),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] rd_q[$];
    string       rd_name_q[$];
    logic [7:0]  con_q[$];
    logic        rd_chk = 1'b0;
    int          n_pass = 0;
    int          n_total = 0;
    int          n_pops = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: compares reads and console pops against queued expectations.
    always @(negedge clk) begin
        logic [31:0] e;
        string       nm;
        if (rd_chk) begin
            if (rd_q.size() == 0) begin
                n_total++;
                $display("FAIL rd_unexpected: got %h expected none", bus.mem_dout);
            end else begin
                e  = rd_q.pop_front();
                nm = rd_name_q.pop_front();
                check(nm, bus.mem_dout, e);
            end
        end
        if (bus.con_valid && bus.con_ready) begin
            n_pops++;
            if (con_q.size() == 0) begin
                n_total++;
                $display("FAIL con_unexpected: got %h expected none", bus.con_data);
            end else begin
                check("con_byte", {24'h0, bus.con_data}, {24'h0, con_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.mem_r   = '0;
        bus.mem_w   = '0;
        bus.mem_din = '0;
        rd_chk      = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] l, input logic [31:0] d);
        bus.mem_addr = a; bus.mem_w = l; bus.mem_din = d;
        tick();
        idle();
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic [3:0] l, input logic [31:0] e);
        bus.mem_addr = a; bus.mem_r = l;
        rd_q.push_back(e); rd_name_q.push_back(nm);
        rd_chk = 1'b1;
        tick();
        idle();
    endtask

    task automatic rw(input string nm, input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
        bus.mem_addr = a; bus.mem_r = 4'hF; bus.mem_w = 4'hF; bus.mem_din = d;
        rd_q.push_back(e); rd_name_q.push_back(nm);
        rd_chk = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.mem_addr = '0; bus.con_ready = 1'b0;
        idle();
        tick(); tick();
        rstl = 1'b0;

        check("rst_con_valid", {31'h0, bus.con_valid}, 32'h0);
        check("rst_drops", {24'h0, bus.con_drops}, 32'h0);
        check("rst_halt", {31'h0, bus.halt}, 32'h0);
        check("rst_halt_code", bus.halt_code, 32'h0);
        check("rst_bus_err", {31'h0, bus.bus_err}, 32'h0);
        rd("rst_con_count", c_CON, 4'b0001, 32'h0);

        // Full-word and single-lane reads, same-cycle read/write
        wr(32'h0, 4'hF, 32'hFFFF_FC18);
        rd("rd_lane0", 32'h0, 4'b0001, 32'h0000_0018);
        rd("rd_word", 32'h0, 4'hF, 32'hFFFF_FC18);
        rw("rw_old", 32'h0, 32'hCAFE_0001, 32'hFFFF_FC18);
        rd("rw_new", 32'h0, 4'hF, 32'hCAFE_0001);

        // Partial and non-contiguous lanes
        wr(32'h4, 4'hF, 32'h1122_3344);
        wr(32'h4, 4'b0010, 32'h0000_AB00);
        rd("rd_merge", 32'h4, 4'hF, 32'h1122_AB44);
        rd("rd_sparse", 32'h4, 4'b0101, 32'h0022_0044);
        wr(32'h8, 4'hF, 32'h0);
        wr(32'h8, 4'b1010, 32'hAABB_CCDD);
        rd("rd_noncontig", 32'h8, 4'hF, 32'hAA00_CC00);

        // Console overflow then drain
        for (int i = 0; i < 10; i++) begin
            if (i < 8) con_q.push_back(8'h41 + 8'(i));
            wr(c_CON, 4'b0001, 32'hFFFF_FF00 | (32'h41 + 32'(i)));
        end
        rd("con_count_full", c_CON, 4'hF, 32'h0000_0008);
        check("con_drops_2", {24'h0, bus.con_drops}, 32'd2);
        bus.con_ready = 1'b1;
        repeat (8) tick();
        check("con_empty_after", {31'h0, bus.con_valid}, 32'h0);
        check("con_pops_8", n_pops, 32'd8);
        bus.con_ready = 1'b0;

        // Push into full FIFO in the same cycle as a pop
        for (int i = 0; i < 8; i++) begin
            con_q.push_back(8'h61 + 8'(i));
            wr(c_CON, 4'b0001, 32'h61 + 32'(i));
        end
        con_q.push_back(8'h5A);
        bus.con_ready = 1'b1;
        wr(c_CON, 4'b0001, 32'h0000_005A);
        repeat (8) tick();
        check("con_full_pop_drops", {24'h0, bus.con_drops}, 32'd2);
        check("con_empty_after2", {31'h0, bus.con_valid}, 32'h0);
        check("con_pops_17", n_pops, 32'd17);
        bus.con_ready = 1'b0;

        // Out-of-range lanes at the top of RAM
        wr(c_MEMB - 2, 4'b0011, 32'h0000_BEEF);
        check("bus_err_clean", {31'h0, bus.bus_err}, 32'h0);
        rd("rd_top_edge", c_MEMB - 2, 4'hF, 32'h0000_BEEF);
        check("bus_err_set", {31'h0, bus.bus_err}, 32'h1);
        tick();
        check("bus_err_sticky", {31'h0, bus.bus_err}, 32'h1);

        // Tohost halt
        wr(c_TOHOST, 4'hF, 32'd42);
        check("halt_set", {31'h0, bus.halt}, 32'h1);
        check("halt_code", bus.halt_code, 32'd42);
        rd("rd_tohost", c_TOHOST, 4'hF, 32'd42);
        wr(32'h0, 4'hF, 32'h1234_5678);
        rd("rd_after_halt", 32'h0, 4'hF, 32'hCAFE_0001);
        wr(c_CON, 4'b0001, 32'h77);
        check("con_halt_ignored", {31'h0, bus.con_valid}, 32'h0);

        rstl = 1'b1;
        tick();
        rstl = 1'b0;
        check("rst2_halt", {31'h0, bus.halt}, 32'h0);
        check("rst2_halt_code", bus.halt_code, 32'h0);
        check("rst2_bus_err", {31'h0, bus.bus_err}, 32'h0);
        check("rst2_drops", {24'h0, bus.con_drops}, 32'h0);
        rd("rd_ram_retained", 32'h0, 4'hF, 32'hCAFE_0001);

        wr(c_TOHOST, 4'b0001, 32'hABCD_EF07);
        check("halt_partial", {31'h0, bus.halt}, 32'h1);
        check("halt_code_partial", bus.halt_code, 32'h0000_0007);

        tick();
        check("rd_q_drained", rd_q.size(), 32'h0);
        check("con_q_drained", con_q.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
